seq_divider_unit: RTL and testbench
===================================

Name: seq_divider_unit

Overview:
- Multi-cycle unsigned restoring divider for the lab ALU.
- Produces quotient and remainder for the divide and MOD operations, alongside the combinational N-bit gate units.
- The ALU result mux consumes Q/R when done pulses.
- One quotient bit per clock: small area, deterministic latency.

Parameters:
- N, 4, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N  dividend (unsigned).
- B  input  N  divisor (unsigned).
- busy  output  1  high while in CALC or DONE.
- done  output  1  one-cycle pulse; Q/R/div_zero valid from this cycle.
- Q  output  N  quotient.
- R  output  N  remainder (= A mod B).
- div_zero  output  1  set when the latched B == 0.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert, any state including mid-operation):
  - state=IDLE; busy=0, done=0, Q=0, R=0, div_zero=0; internal regs and count=0.
  - Deassertion is synchronous to clk; the in-flight division is discarded.
- States IDLE, CALC, DONE.
- IDLE:
  - On edge with start=1 and B!=0: latch A into quotient shift reg, B into divisor reg, partial remainder P(N+1 bits)=0, count=0; go to CALC.
  - On edge with start=1 and B==0: Q=all ones, R=A, div_zero=1; go to DONE.
  - start=0: stay; outputs hold last result.
- CALC, each edge:
  - {P,Qs} shifted left 1; T = P_shifted - {1'b0,divisor} in N+1 bits.
  - If T MSB==0: P=T, Qs LSB=1; else P unchanged (restore), Qs LSB=0.
  - count++.
  - At the edge where count reaches N-1 (Nth iteration): write Q=Qs, R=P[N-1:0], div_zero=0; go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: start sampled at edge k, B!=0 → done high in the cycle after edge k+N. B==0 → done high in the cycle after edge k.
- Throughput: a new start is accepted no earlier than the IDLE cycle after DONE.
- start while busy=1 is ignored; A/B changes while busy have no effect (operands latched).
- Q/R/div_zero hold their values until the next accepted start completes; they do not change in the cycle between start and done.
- Width rules: all arithmetic unsigned. P uses N+1 bits so the subtraction borrow is the MSB; no truncation of the final remainder, since R < B always holds.
- A < B: Q=0, R=A. A==0: Q=0, R=0. B==1: Q=A, R=0.
- busy = (state != IDLE); done = (state == DONE); both registered-state decodes, no combinational path from start.

Test Plan:
- Reset mid-op: N=4, start A=13 B=3, assert rst_n=0 at CALC count=2 → outputs 0 immediately (async); after release, start A=9 B=2 → Q=4 R=1 with correct latency.
- Basic: N=4, A=13 B=3, start 1 cycle → busy next cycle, done exactly N+1=5 cycles after the start edge; Q=4 R=1 div_zero=0; done high exactly 1 cycle.
- Boundaries: (A=15,B=1)→Q=15 R=0; (A=2,B=7)→Q=0 R=2; (A=0,B=5)→Q=0 R=0; (A=15,B=15)→Q=1 R=0.
- Divide by zero: A=9 B=0 → done in the cycle after the start edge; Q=4'hF R=9 div_zero=1; a following A=8 B=2 clears div_zero and gives Q=4 R=0.
- Ignored start: pulse start with A=6 B=3 while busy from A=14 B=4 → result Q=3 R=2 only; no second done; then back-to-back start in IDLE is accepted.
- Random sweep: N=8, 1000 random A/B including B=0 → Q==A/B and R==A%B (B!=0) against a scoreboard; done count equals accepted starts.

Source files
------------

// File: rtl/seq_divider_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, N iterations.
// Divide-by-zero short-circuits straight to DONE with Q = all ones, R = A.
module seq_divider_unit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  p_q, p_d;
    logic [N-1:0]  qs_q, qs_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dz_q, dz_d;

    logic          b_zero;
    logic          last_iter;
    logic [N:0]    p_sh;
    logic [N:0]    t;
    logic [N-1:0]  p_nx;
    logic [N-1:0]  qs_nx;

    assign b_zero    = (B == '0);
    assign last_iter = (count_q == CW'(N - 1));

    // Partial remainder is always < divisor, so the shifted value fits N+1 bits
    // and the subtraction borrow lands in t[N].
    assign p_sh  = {p_q, qs_q[N-1]};
    assign t     = p_sh - {1'b0, dvs_q};
    assign p_nx  = t[N] ? p_sh[N-1:0] : t[N-1:0];
    assign qs_nx = {qs_q[N-2:0], ~t[N]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        count_d = count_q;
        p_d     = p_q;
        qs_d    = qs_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b_zero) begin
                        q_d  = '1;
                        r_d  = A;
                        dz_d = 1'b1;
                    end else begin
                        qs_d    = A;
                        dvs_d   = B;
                        p_d     = '0;
                        count_d = '0;
                    end
                end
            end
            S_CALC: begin
                p_d     = p_nx;
                qs_d    = qs_nx;
                count_d = count_q + CW'(1);
                if (last_iter) begin
                    q_d  = qs_nx;
                    r_d  = p_nx;
                    dz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            p_q     <= '0;
            qs_q    <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            p_q     <= p_d;
            qs_q    <= qs_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider_unit.sv
// Scoreboard bench for seq_divider_unit: directed N=4 cases plus an N=8 sweep.
module tb_seq_divider_unit;

    localparam int N4 = 4;
    localparam int N8 = 8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, dz4;
    logic [3:0] q4, r4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] q8, r8;

    exp_t sb4[$];
    exp_t sb8[$];

    int tests = 0;
    int fails = 0;
    int done8_cnt = 0;
    int ops8 = 0;
    logic [3:0] last_q4 = '0, last_r4 = '0;

    always #5 clk = ~clk;

    seq_divider_unit #(.N(N4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Q(q4), .R(r4), .div_zero(dz4)
    );

    seq_divider_unit #(.N(N8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Q(q8), .R(r8), .div_zero(dz8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a done pulse is seen.
    always @(negedge clk) begin
        if (done4) begin
            if (sb4.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL u4_unexpected_done: got done with Q=%0h R=%0h, expected no done", q4, r4);
            end else begin
                exp_t e;
                e = sb4.pop_front();
                check("u4_Q", {28'b0, q4}, {24'b0, e.q});
                check("u4_R", {28'b0, r4}, {24'b0, e.r});
                check("u4_div_zero", {31'b0, dz4}, {31'b0, e.dz});
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            done8_cnt++;
            if (sb8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL u8_unexpected_done: got done with Q=%0h R=%0h, expected no done", q8, r8);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                check("u8_Q", {24'b0, q8}, {24'b0, e.q});
                check("u8_R", {24'b0, r8}, {24'b0, e.r});
                check("u8_div_zero", {31'b0, dz8}, {31'b0, e.dz});
            end
        end
    end

    task automatic wait_idle4();
        int g = 0;
        @(negedge clk);
        while (busy4 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("u4_idle_timeout", 32'(g), 32'd0);
    endtask

    task automatic wait_idle8();
        int g = 0;
        @(negedge clk);
        while (busy8 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("u8_idle_timeout", 32'(g), 32'd0);
    endtask

    // One N=4 division; glitch pulses a second start (A=6,B=3) while busy.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                       input logic [3:0] er, input logic edz, input bit glitch);
        int cyc = 0;
        int lat;
        exp_t e;
        wait_idle4();
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        e.q = {4'b0, eq};
        e.r = {4'b0, er};
        e.dz = edz;
        sb4.push_back(e);
        check("u4_busy_after_start", {31'b0, busy4}, 32'd1);
        lat = (b == 4'd0) ? 0 : N4;
        if (b != 4'd0) begin
            check("u4_Q_hold", {28'b0, q4}, {28'b0, last_q4});
            check("u4_R_hold", {28'b0, r4}, {28'b0, last_r4});
        end
        while (!done4 && cyc < 40) begin
            if (glitch && cyc == 1) begin
                @(negedge clk);
                a4 = 4'd6;
                b4 = 4'd3;
                start4 = 1'b1;
                @(posedge clk);
                #1 start4 = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            cyc++;
        end
        check("u4_latency", 32'(cyc), 32'(lat));
        @(posedge clk);
        #1;
        check("u4_done_one_cycle", {31'b0, done4}, 32'd0);
        check("u4_idle_after_done", {31'b0, busy4}, 32'd0);
        last_q4 = eq;
        last_r4 = er;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int cyc = 0;
        int lat;
        exp_t e;
        wait_idle8();
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        if (b == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
            e.dz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 1'b0;
        end
        sb8.push_back(e);
        ops8++;
        lat = (b == 8'd0) ? 0 : N8;
        while (!done8 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("u8_latency", 32'(cyc), 32'(lat));
    endtask

    initial begin
        logic [7:0] ra, rb;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy4}, 32'd0);
        check("rst_done", {31'b0, done4}, 32'd0);
        check("rst_Q", {28'b0, q4}, 32'd0);
        check("rst_R", {28'b0, r4}, 32'd0);
        check("rst_div_zero", {31'b0, dz4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0);

        // Async reset two iterations into a division
        wait_idle4();
        a4 = 4'd13;
        b4 = 4'd3;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy4}, 32'd0);
        check("midrst_done", {31'b0, done4}, 32'd0);
        check("midrst_Q", {28'b0, q4}, 32'd0);
        check("midrst_R", {28'b0, r4}, 32'd0);
        check("midrst_div_zero", {31'b0, dz4}, 32'd0);
        last_q4 = '0;
        last_r4 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        op4(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0);

        // Boundaries
        op4(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
        op4(4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 1'b0);
        op4(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        op4(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0);

        // Divide by zero, then a normal division clears div_zero
        op4(4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1'b0);
        op4(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 1'b0);

        // Start while busy is ignored; then back-to-back accepted starts
        op4(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
        op4(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0);
        op4(4'd11, 4'd5, 4'd2, 4'd1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("u4_sb_drained", 32'(sb4.size()), 32'd0);

        // N=8 sweep including B=0
        op8(8'd255, 8'd1);
        op8(8'd200, 8'd0);
        op8(8'd100, 8'd255);
        for (int i = 0; i < 997; i++) begin
            ra = 8'($urandom_range(0, 255));
            if (i % 10 == 0) rb = 8'd0;
            else if (i % 10 == 1) rb = 8'($urandom_range(1, 4));
            else rb = 8'($urandom_range(1, 255));
            op8(ra, rb);
        end
        repeat (4) @(posedge clk);
        #1;
        check("u8_done_count", 32'(done8_cnt), 32'(ops8));
        check("u8_sb_drained", 32'(sb8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
